uart_tx_sched: RTL and testbench

Round-robin scheduler that shares one UART transmitter between `N_REQ` word-producing requesters. It accepts a `WORD_BYTES`-byte word from the granted requester and serializes it LSB-byte-first into the transmitter's `sdata`/`tx_start`/`tx_busy` byte interface. It sits between core-side producers (e.g. result dump, debug trace) and the UART transmitter in the loopback/IO path.

---
 rtl/uart_pkg.sv | 16 +
 rtl/rr_arbiter.sv | 35 +++
 rtl/uart_tx_sched.sv | 86 ++++++++
 tb/tb_uart_tx_sched.sv | 171 +++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// uart_pkg: shared types and helpers for the UART transmit scheduler and its arbiter.
//   sched_state_t : scheduler FSM states
//   BYTE_W        : width of one transmitted byte
//   clog2_min1    : $clog2 clamped to at least 1 bit for index/counter widths
package uart_pkg;
  localparam int BYTE_W = 8;
  typedef enum logic [1:0] {
    S_IDLE      = 2'd0,
    S_START     = 2'd1,
    S_WAIT_BUSY = 2'd2,
    S_WAIT_DONE = 2'd3
  } sched_state_t;
  function automatic int clog2_min1(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: combinational round-robin arbiter, lowest index at or above ptr wins, wrapping to 0.
//   req     : request vector
//   ptr     : index searched first
//   en      : grants are only issued while high
//   gnt     : one-hot grant
//   gnt_idx : index of the granted request (0 when nothing is granted)
module rr_arbiter
  import uart_pkg::*;
#(
  parameter int N  = 2,
  parameter int IW = clog2_min1(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  input  logic          en,
  output logic [N-1:0]  gnt,
  output logic [IW-1:0] gnt_idx
);
  logic          found;
  logic [IW-1:0] idx;
  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    found   = 1'b0;
    idx     = '0;
    for (int k = 0; k < N; k++) begin
      idx = IW'((int'(ptr) + k) % N);
      if (en && !found && req[idx]) begin
        found        = 1'b1;
        gnt[idx]     = 1'b1;
        gnt_idx      = idx;
      end
    end
  end
endmodule

// File: rtl/uart_tx_sched.sv
// uart_tx_sched: round-robin scheduler feeding WORD_BYTES-byte words, LSB byte first, into one UART transmitter.
//   clk, rstn      : clock, synchronous active-low reset
//   req_valid/data : per-requester word offers (requester i at bits [i*W*8 +: W*8])
//   req_ready      : one-hot accept pulse, only in idle
//   tx_sdata/start : byte and start pulse to the transmitter
//   tx_busy        : transmitter busy, only looked at while waiting on a byte
//   sched_active   : a word is in flight
//   sched_grant    : index of the current or most recent grant
module uart_tx_sched
  import uart_pkg::*;
#(
  parameter int N_REQ      = 2,
  parameter int WORD_BYTES = 4
) (
  input  logic                               clk,
  input  logic                               rstn,
  input  logic [N_REQ-1:0]                   req_valid,
  input  logic [N_REQ*WORD_BYTES*BYTE_W-1:0] req_data,
  output logic [N_REQ-1:0]                   req_ready,
  output logic [BYTE_W-1:0]                  tx_sdata,
  output logic                               tx_start,
  input  logic                               tx_busy,
  output logic                               sched_active,
  output logic [clog2_min1(N_REQ)-1:0]       sched_grant
);
  localparam int GW = clog2_min1(N_REQ);
  localparam int CW = clog2_min1(WORD_BYTES);
  localparam int DW = WORD_BYTES * BYTE_W;
  sched_state_t  state_q, state_d;
  logic [GW-1:0] ptr_q, ptr_d, grant_q, grant_d, gnt_idx;
  logic [DW-1:0] shreg_q, shreg_d;
  logic [CW-1:0] cnt_q, cnt_d;
  // Gating with rstn keeps req_ready low during the reset cycle even though the state already reads idle.
  rr_arbiter #(.N(N_REQ), .IW(GW)) u_arb (
    .req     (req_valid),
    .ptr     (ptr_q),
    .en      (state_q == S_IDLE && rstn),
    .gnt     (req_ready),
    .gnt_idx (gnt_idx)
  );
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    grant_d = grant_q;
    shreg_d = shreg_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_IDLE: if (|req_valid) begin
        state_d = S_START;
        shreg_d = req_data[int'(gnt_idx)*DW +: DW];
        cnt_d   = '0;
        grant_d = gnt_idx;
        ptr_d   = (int'(gnt_idx) == N_REQ - 1) ? '0 : gnt_idx + 1'b1;
      end
      S_START:     state_d = S_WAIT_BUSY;
      S_WAIT_BUSY: state_d = tx_busy ? S_WAIT_DONE : S_WAIT_BUSY;
      S_WAIT_DONE: if (!tx_busy) begin
        if (int'(cnt_q) == WORD_BYTES - 1) state_d = S_IDLE;
        else begin
          state_d = S_START;
          shreg_d = shreg_q >> BYTE_W;
          cnt_d   = cnt_q + 1'b1;
        end
      end
    endcase
  end
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q <= S_IDLE;
      ptr_q   <= '0;
      grant_q <= '0;
      shreg_q <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      grant_q <= grant_d;
      shreg_q <= shreg_d;
      cnt_q   <= cnt_d;
    end
  end
  assign tx_start     = (state_q == S_START);
  assign tx_sdata     = (state_q == S_IDLE) ? '0 : shreg_q[BYTE_W-1:0];
  assign sched_active = (state_q != S_IDLE);
  assign sched_grant  = grant_q;
endmodule

// File: tb/tb_uart_tx_sched.sv
// tb_uart_tx_sched: directed bench for uart_tx_sched with a cycle-accurate transmitter busy model.
module tb_uart_tx_sched;
  localparam int FRAME = 80;
  logic        clk = 1'b0;
  logic        rstn;
  logic [2:0]  a_valid;
  logic [95:0] a_data;
  logic [2:0]  a_ready;
  logic [7:0]  a_sdata;
  logic        a_start, a_busy, a_active;
  logic [1:0]  a_grant;
  logic [0:0]  b_valid;
  logic [7:0]  b_data;
  logic [0:0]  b_ready;
  logic [7:0]  b_sdata;
  logic        b_start, b_busy, b_active;
  logic [0:0]  b_grant;
  int          a_bc, b_bc, cyc, a_wide, b_wide;
  logic        a_prev, b_prev;
  logic [7:0]  a_bytes[$], b_bytes[$];
  int          a_t[$], b_t[$], a_gnts[$];
  int          errors = 0, checks = 0;
  logic [2:0]  seen;

  always #5 clk = ~clk;

  uart_tx_sched #(.N_REQ(3), .WORD_BYTES(4)) dut_a (
    .clk(clk), .rstn(rstn), .req_valid(a_valid), .req_data(a_data), .req_ready(a_ready),
    .tx_sdata(a_sdata), .tx_start(a_start), .tx_busy(a_busy), .sched_active(a_active), .sched_grant(a_grant)
  );
  uart_tx_sched #(.N_REQ(1), .WORD_BYTES(1)) dut_b (
    .clk(clk), .rstn(rstn), .req_valid(b_valid), .req_data(b_data), .req_ready(b_ready),
    .tx_sdata(b_sdata), .tx_start(b_start), .tx_busy(b_busy), .sched_active(b_active), .sched_grant(b_grant)
  );

  // Transmitter model: busy rises the cycle after start is sampled and stays high for one frame.
  always @(posedge clk) begin
    if (!rstn) begin
      a_busy <= 1'b0; a_bc <= 0; b_busy <= 1'b0; b_bc <= 0;
    end else begin
      if (a_start) begin a_busy <= 1'b1; a_bc <= FRAME - 1; end
      else if (a_busy) begin if (a_bc == 0) a_busy <= 1'b0; else a_bc <= a_bc - 1; end
      if (b_start) begin b_busy <= 1'b1; b_bc <= FRAME - 1; end
      else if (b_busy) begin if (b_bc == 0) b_busy <= 1'b0; else b_bc <= b_bc - 1; end
    end
  end

  always @(posedge clk) begin
    cyc    <= cyc + 1;
    a_prev <= a_start;
    b_prev <= b_start;
    if (a_start && a_prev) a_wide <= a_wide + 1;
    if (b_start && b_prev) b_wide <= b_wide + 1;
    if (a_start) begin a_bytes.push_back(a_sdata); a_t.push_back(cyc); end
    if (b_start) begin b_bytes.push_back(b_sdata); b_t.push_back(cyc); end
    if (|(a_valid & a_ready)) a_gnts.push_back(a_ready[1] ? 1 : a_ready[2] ? 2 : 0);
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] a_word(input int base);
    return {a_bytes[base+3], a_bytes[base+2], a_bytes[base+1], a_bytes[base]};
  endfunction

  task automatic wait_a_idle(input string tag);
    int n = 0;
    while (a_active && n < 2000) begin @(negedge clk); n++; end
    chk(tag, a_active, 0);
  endtask

  initial begin
    cyc = 0; a_wide = 0; b_wide = 0; a_prev = 0; b_prev = 0;
    rstn = 1'b0; a_valid = '0; a_data = '0; b_valid = '0; b_data = '0;
    repeat (3) @(negedge clk);
    chk("rst_active", a_active, 0);
    chk("rst_start", a_start, 0);
    chk("rst_sdata", a_sdata, 0);
    chk("rst_grant", a_grant, 0);
    chk("rst_b_active", b_active, 0);
    // 1: single word from requester 0
    rstn = 1'b1; a_valid = 3'b001; a_data[31:0] = 32'h12345678; #1;
    chk("t1_ready", a_ready, 3'b001);
    @(negedge clk);
    chk("t1_start_a1", a_start, 1);
    chk("t1_sdata0", a_sdata, 8'h78);
    chk("t1_ready_pulse", a_ready, 0);
    chk("t1_active", a_active, 1);
    a_valid = '0;
    wait_a_idle("t1_idle");
    chk("t1_nstart", a_bytes.size(), 4);
    chk("t1_word", a_word(0), 32'h12345678);
    chk("t1_gap", a_t[1] - a_t[0], FRAME + 2);
    chk("t1_sdata_idle", a_sdata, 0);
    // 2: simultaneous requests from a fresh pointer
    rstn = 1'b0; @(negedge clk); rstn = 1'b1;
    a_bytes.delete(); a_gnts.delete();
    a_data[31:0] = 32'hAAAAAAAA; a_data[63:32] = 32'h55555555; a_valid = 3'b011;
    for (int n = 0; n < 2000 && a_gnts.size() < 4; n++) @(negedge clk);
    a_valid = '0;
    chk("t2_ngnt", a_gnts.size(), 4);
    wait_a_idle("t2_idle");
    for (int i = 0; i < 4; i++) chk("t2_gnt", a_gnts[i], i % 2);
    for (int i = 0; i < 4; i++) chk("t2_word", a_word(4 * i), (i % 2) ? 32'h55555555 : 32'hAAAAAAAA);
    // 3: pointer sits at 2, requester 1 alone must still win by wrapping
    a_bytes.delete();
    a_data[63:32] = 32'hCAFEF00D; a_data[95:64] = 32'h0BADBEEF; a_valid = 3'b010; #1;
    chk("t3_ready_wrap", a_ready, 3'b010);
    @(negedge clk); a_valid = '0;
    chk("t3_grant", a_grant, 1);
    wait_a_idle("t3_idle1");
    a_valid = 3'b110; #1;
    chk("t3_ptr2", a_ready, 3'b100);
    @(negedge clk); a_valid = '0;
    chk("t3_grant2", a_grant, 2);
    wait_a_idle("t3_idle2");
    chk("t3_word1", a_word(0), 32'hCAFEF00D);
    chk("t3_word2", a_word(4), 32'h0BADBEEF);
    // 5: held request and data change while active
    a_bytes.delete();
    a_data[31:0] = 32'hDEADBEEF; a_data[63:32] = 32'h87654321; a_valid = 3'b001; #1;
    chk("t5_ready0", a_ready, 3'b001);
    @(negedge clk);
    a_data[31:0] = 32'h11111111; a_valid = 3'b011; seen = '0;
    for (int n = 0; n < 2000 && a_active; n++) begin @(negedge clk); if (a_active) seen |= a_ready; end
    chk("t5_no_ready_active", seen, 0);
    chk("t5_ready1_idle", a_ready, 3'b010);
    @(negedge clk); a_valid = '0;
    wait_a_idle("t5_idle");
    chk("t5_word0", a_word(0), 32'hDEADBEEF);
    chk("t5_word1", a_word(4), 32'h87654321);
    // 4: reset after second start, then a clean word
    a_bytes.delete();
    a_data[95:64] = 32'hA1B2C3D4; a_valid = 3'b100;
    for (int n = 0; n < 2000 && a_bytes.size() < 2; n++) @(negedge clk);
    chk("t4_sdata1", a_sdata, 8'hC3);
    rstn = 1'b0;
    @(negedge clk);
    chk("t4_active", a_active, 0);
    chk("t4_start", a_start, 0);
    chk("t4_sdata", a_sdata, 0);
    chk("t4_ready", a_ready, 0);
    chk("t4_grant", a_grant, 0);
    rstn = 1'b1; a_bytes.delete();
    a_data[31:0] = 32'h000000FF; a_valid = 3'b001; #1;
    chk("t4_ready_after", a_ready, 3'b001);
    @(negedge clk); a_valid = '0;
    wait_a_idle("t4_idle");
    chk("t4_nbytes", a_bytes.size(), 4);
    chk("t4_word", a_word(0), 32'h000000FF);
    chk("a_pulse_width", a_wide, 0);
    // 6: single-byte back-to-back stream
    b_data = 8'h5A; b_valid = 1'b1;
    for (int n = 0; n < 2000 && b_bytes.size() < 4; n++) @(negedge clk);
    b_valid = 1'b0;
    chk("t6_nstart", b_bytes.size(), 4);
    for (int i = 1; i < 4; i++) chk("t6_interval", b_t[i] - b_t[i-1], FRAME + 3);
    for (int i = 0; i < 4; i++) chk("t6_byte", b_bytes[i], 8'h5A);
    for (int n = 0; n < 2000 && b_active; n++) @(negedge clk);
    chk("t6_idle", b_active, 0);
    chk("t6_width", b_wide, 0);
    chk("t6_grant", b_grant, 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
